// File: rtl/controle_magnetron_potencia_pkg.sv
// Shared definitions for the magnetron power controller: FSM state codes,
// default power-level parameters and the duty-counter width helper.
package controle_magnetron_potencia_pkg;
  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    AQUECENDO = 2'd1,
    PAUSADO   = 2'd2
  } estado_t;

  localparam int N_NIVEIS_PADRAO = 4;
  localparam int PASSO_PADRAO    = 2;

  // A one-clock period would give $clog2 = 0; keep at least one counter bit.
  function automatic int larg_cont(input int periodo);
    return (periodo > 1) ? $clog2(periodo) : 1;
  endfunction
endpackage

// File: rtl/controle_magnetron_potencia_gerador_ciclo.sv
// Duty-period counter with the power-level compare: reports the magnetron-on
// window and the last clock of each period.
module gerador_ciclo
  import controle_magnetron_potencia_pkg::*;
#(
  parameter int N_NIVEIS = N_NIVEIS_PADRAO,
  parameter int PASSO    = PASSO_PADRAO,
  parameter int NW       = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_conta,
  input  logic          i_limpa,
  input  logic [NW-1:0] i_nivel,
  output logic          o_janela,
  output logic          o_fim
);
  localparam int PERIODO = N_NIVEIS * PASSO;
  localparam int CW      = larg_cont(PERIODO);
  localparam logic [CW-1:0] ULTIMO  = CW'(PERIODO - 1);
  localparam logic [CW:0]   PASSO_W = (CW + 1)'(PASSO);

  logic [CW-1:0] r_cont;
  logic [CW:0]   w_limite;

  // i_nivel is saturated upstream, so the product never exceeds PERIODO.
  assign w_limite = (CW + 1)'(i_nivel) * PASSO_W;
  assign o_janela = {1'b0, r_cont} < w_limite;
  assign o_fim    = (r_cont == ULTIMO);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       r_cont <= '0;
    else if (i_limpa)  r_cont <= '0;
    else if (i_conta)  r_cont <= (r_cont == ULTIMO) ? '0 : r_cont + 1'b1;
  end
endmodule

// File: rtl/controle_magnetron_potencia.sv
// Microwave magnetron power controller: idle/heating/paused FSM driving a
// duty-cycled magnetron enable from a latched power level.
module controle_magnetron_potencia
  import controle_magnetron_potencia_pkg::*;
#(
  parameter int N_NIVEIS = N_NIVEIS_PADRAO,
  parameter int PASSO    = PASSO_PADRAO,
  parameter int NW       = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          startn,
  input  logic          stopn,
  input  logic          clearn,
  input  logic          door_closed,
  input  logic          timer_done,
  input  logic [NW-1:0] nivel,
  output logic          mag_on,
  output logic [1:0]    estado,
  output logic          ciclo_fim
);
  localparam logic [NW-1:0] NIVEL_MAX = NW'(N_NIVEIS);

  estado_t       r_estado, w_prox;
  logic [NW-1:0] r_nivel;
  logic [NW-1:0] w_nivel_sat;
  logic          w_conta, w_limpa, w_entra;
  logic          w_janela, w_fim;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_estado <= OCIOSO;
    else         r_estado <= w_prox;
  end

  // Only a clean timer_done==0 lets the FSM leave or stay out of OCIOSO;
  // an unknown timer value falls into the idle branch.
  always_comb begin
    w_prox = r_estado;
    if (!clearn) begin
      w_prox = OCIOSO;
    end else if (timer_done == 1'b0) begin
      case (r_estado)
        OCIOSO:    if (stopn && door_closed && !startn) w_prox = AQUECENDO;
        AQUECENDO: if (!stopn || !door_closed)          w_prox = PAUSADO;
        PAUSADO: begin
          if (!stopn)                        w_prox = OCIOSO;
          else if (door_closed && !startn)   w_prox = AQUECENDO;
        end
        default:                             w_prox = OCIOSO;
      endcase
    end else begin
      w_prox = OCIOSO;
    end
  end

  assign w_nivel_sat = (nivel > NIVEL_MAX) ? NIVEL_MAX : nivel;
  assign w_entra     = (r_estado == OCIOSO) && (w_prox == AQUECENDO);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      r_nivel <= '0;
    else if (w_entra) r_nivel <= w_nivel_sat;
  end

  // Counter advances only across heating-to-heating clocks, so a pause
  // resumes at the same duty position it was interrupted at.
  assign w_conta = (r_estado == AQUECENDO) && (w_prox == AQUECENDO);
  assign w_limpa = (w_prox == OCIOSO);

  gerador_ciclo #(
    .N_NIVEIS (N_NIVEIS),
    .PASSO    (PASSO),
    .NW       (NW)
  ) u_gerador_ciclo (
    .clk      (clk),
    .resetn   (resetn),
    .i_conta  (w_conta),
    .i_limpa  (w_limpa),
    .i_nivel  (r_nivel),
    .o_janela (w_janela),
    .o_fim    (w_fim)
  );

  assign estado    = r_estado;
  assign mag_on    = (r_estado == AQUECENDO) && w_janela && door_closed;
  assign ciclo_fim = (r_estado == AQUECENDO) && w_fim;
endmodule

// File: tb/tb_controle_magnetron_potencia.sv
// Directed scoreboard bench for the magnetron power controller
// (N_NIVEIS=4, PASSO=2, PERIODO=8).
module tb_controle_magnetron_potencia;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
  logic       door_closed = 1'b1, timer_done = 1'b0;
  logic [2:0] nivel = 3'd0;
  logic       mag_on, ciclo_fim;
  logic [1:0] estado;

  // control word {startn, stopn, clearn, door_closed, timer_done}
  localparam logic [4:0] C_IDLE        = 5'b11110;
  localparam logic [4:0] C_START       = 5'b01110;
  localparam logic [4:0] C_CLEAR       = 5'b11010;
  localparam logic [4:0] C_STOP        = 5'b10110;
  localparam logic [4:0] C_PORTA       = 5'b11100;
  localparam logic [4:0] C_PORTA_START = 5'b01100;
  localparam logic [4:0] C_START_CLEAR = 5'b01010;
  localparam logic [4:0] C_START_STOP  = 5'b00110;
  localparam logic [4:0] C_TIMER_START = 5'b01111;

  typedef struct packed {
    logic       mag;
    logic [1:0] est;
    logic       fim;
  } exp_t;

  exp_t  q[$];
  string tq[$];
  int    n_chk = 0, n_err = 0;
  int    m_est = 0, m_cnt = 0, m_niv = 0;

  controle_magnetron_potencia dut (
    .clk         (clk),
    .resetn      (resetn),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .timer_done  (timer_done),
    .nivel       (nivel),
    .mag_on      (mag_on),
    .estado      (estado),
    .ciclo_fim   (ciclo_fim)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t esperado();
    exp_t e;
    e.mag = (m_est == 1) && (m_cnt < m_niv * 2) && (door_closed == 1'b1);
    e.est = 2'(m_est);
    e.fim = (m_est == 1) && (m_cnt == 7);
    return e;
  endfunction

  function automatic int prox(input int s);
    if (!clearn)     return 0;
    if (timer_done)  return 0;
    if (!stopn)      return (s == 1) ? 2 : 0;
    if (!door_closed) return (s == 1) ? 2 : s;
    if (!startn)     return (s == 0 || s == 2) ? 1 : s;
    return s;
  endfunction

  function automatic void modelo_borda();
    int ns;
    ns = prox(m_est);
    if (m_est == 0 && ns == 1) m_niv = (nivel > 3'd4) ? 4 : int'(nivel);
    if (ns == 0)                    m_cnt = 0;
    else if (m_est == 1 && ns == 1) m_cnt = (m_cnt + 1) % 8;
    m_est = ns;
  endfunction

  task automatic empilha(input string t);
    q.push_back(esperado());
    tq.push_back(t);
  endtask

  task automatic confere();
    exp_t  e;
    string t;
    n_chk++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = q.pop_front();
    t = tq.pop_front();
    assert ({mag_on, estado, ciclo_fim} === e) else begin
      n_err++;
      $error("FAIL %s: got mag_on=%0b estado=%0d ciclo_fim=%0b, expected mag_on=%0b estado=%0d ciclo_fim=%0b",
             t, mag_on, estado, ciclo_fim, e.mag, e.est, e.fim);
    end
  endtask

  // Drive at negedge, check combinational outputs, then check post-edge state.
  task automatic passo(input logic [4:0] c, input logic [2:0] nv, input string tag);
    @(negedge clk);
    {startn, stopn, clearn, door_closed, timer_done} = c;
    nivel = nv;
    #1;
    empilha({tag, "/pre"});
    confere();
    modelo_borda();
    empilha({tag, "/pos"});
    @(posedge clk);
    #1;
    confere();
  endtask

  initial begin
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    empilha("reset");
    confere();
    @(negedge clk);
    resetn = 1'b1;

    // level 2: 1111 0000, nivel changes while heating are ignored
    passo(C_START, 3'd2, "inicio_n2");
    for (int i = 0; i < 17; i++) passo(C_IDLE, (i % 2) ? 3'd7 : 3'd1, "duty_n2");
    passo(C_CLEAR, 3'd2, "clear_n2");

    // door opens at counter 2, resume keeps position
    passo(C_START, 3'd3, "inicio_n3");
    passo(C_IDLE, 3'd3, "n3_c1");
    passo(C_IDLE, 3'd3, "n3_c2");
    passo(C_PORTA, 3'd3, "porta_abre");
    passo(C_PORTA, 3'd3, "porta_aberta");
    passo(C_PORTA_START, 3'd3, "start_porta_aberta");
    passo(C_START, 3'd0, "retoma");
    for (int i = 0; i < 7; i++) passo(C_IDLE, 3'd0, "n3_segue");
    passo(C_CLEAR, 3'd0, "clear_n3");

    // saturation and zero level
    passo(C_START, 3'd7, "inicio_sat");
    for (int i = 0; i < 9; i++) passo(C_IDLE, 3'd7, "sat_n4");
    passo(C_CLEAR, 3'd0, "clear_sat");
    passo(C_START, 3'd0, "inicio_n0");
    for (int i = 0; i < 9; i++) passo(C_IDLE, 3'd0, "nivel0");
    passo(C_CLEAR, 3'd0, "clear_n0");

    // stop twice, start blocked by clear / stop / open door
    passo(C_START, 3'd2, "inicio_stop");
    for (int i = 0; i < 3; i++) passo(C_IDLE, 3'd2, "antes_stop");
    passo(C_STOP, 3'd2, "stop1");
    passo(C_STOP, 3'd2, "stop2");
    passo(C_START_CLEAR, 3'd2, "start_com_clear");
    passo(C_START_STOP, 3'd2, "start_com_stop");
    passo(C_PORTA_START, 3'd2, "start_porta_ocioso");

    // timer wins over start; async reset mid-period
    passo(C_START, 3'd3, "inicio_timer");
    for (int i = 0; i < 2; i++) passo(C_IDLE, 3'd3, "antes_timer");
    passo(C_TIMER_START, 3'd3, "timer_com_start");
    passo(C_IDLE, 3'd3, "apos_timer");
    passo(C_START, 3'd4, "inicio_reset");
    for (int i = 0; i < 3; i++) passo(C_IDLE, 3'd4, "antes_reset");
    #2;
    resetn = 1'b0;
    #1;
    m_est = 0; m_cnt = 0; m_niv = 0;
    empilha("reset_async");
    confere();
    @(negedge clk);
    resetn = 1'b1;
    passo(C_IDLE, 3'd4, "pos_reset");
    passo(C_START, 3'd1, "inicio_n1");
    for (int i = 0; i < 8; i++) passo(C_IDLE, 3'd1, "duty_n1");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
